fib_stream_checker: RTL and testbench

- Receiving end of the Fibonacci sequencer's `data` output.
- Accepts a stream of WIDTH-bit terms over a valid/ready handshake.
- Checks that the first two terms equal the programmed seeds and that every later term equals the sum of the previous two, modulo 2^WIDTH.
- Counts the terms, raises Done after TERMS terms, and latches the index and value of the first mismatch.

---
 rtl/fib_stream_checker.sv | 105 ++++++++++
 tb/tb_fib_stream_checker.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/fib_stream_checker.sv
// Receiving end of a Fibonacci term stream: checks seeds and the running
// sum rule modulo 2^WIDTH, counts terms, and latches the first mismatch.
module fib_stream_checker #(
  parameter int WIDTH  = 4,
  parameter int TERMS  = 15,
  parameter int SEED_A = 1,
  parameter int SEED_B = 1
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             START,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             Done,
  output logic             Error,
  output logic [7:0]       err_index,
  output logic [WIDTH-1:0] err_value,
  output logic [7:0]       term_count,
  output logic [1:0]       fsm_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEED  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [7:0]       LAST_IDX = 8'(TERMS - 1);
  localparam logic [WIDTH-1:0] SEED_A_V = WIDTH'(SEED_A);
  localparam logic [WIDTH-1:0] SEED_B_V = WIDTH'(SEED_B);

  state_t           state, state_nx;
  logic [WIDTH-1:0] prev1, prev2;
  logic [WIDTH-1:0] expected;
  logic             accept;
  logic             mismatch;

  // Handshake: a term transfers on a rising edge only when in_valid and
  // in_ready are both 1; in_ready depends on state alone, never on in_valid.
  assign in_ready  = (state == SEED) || (state == CHECK);
  assign Done      = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign fsm_state = state;

  always_comb begin
    expected = prev1 + prev2;
    if (state == SEED) begin
      expected = (term_count == 8'd0) ? SEED_A_V : SEED_B_V;
    end
  end

  assign mismatch = accept && (in_data != expected);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (START) state_nx = SEED;
      SEED: begin
        if (accept && (term_count == 8'd1)) begin
          state_nx = (TERMS == 2) ? DONE : CHECK;
        end
      end
      CHECK: if (accept && (term_count == LAST_IDX)) state_nx = DONE;
      DONE:  if (!START) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // History always takes the received value, so one bad term ripples forward.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      prev1      <= '0;
      prev2      <= '0;
      term_count <= 8'd0;
      Error      <= 1'b0;
      err_index  <= 8'd0;
      err_value  <= '0;
    end else if ((state == IDLE) && START) begin
      term_count <= 8'd0;
      Error      <= 1'b0;
      err_index  <= 8'd0;
      err_value  <= '0;
    end else if (accept) begin
      term_count <= term_count + 8'd1;
      prev2      <= prev1;
      prev1      <= in_data;
      if (mismatch && !Error) begin
        Error     <= 1'b1;
        err_index <= term_count;
        err_value <= in_data;
      end
    end
  end

endmodule

// File: tb/tb_fib_stream_checker.sv
// Randomized bench for fib_stream_checker; expected values come from a
// plain-arithmetic model of the Fibonacci rule over the received stream.
module tb_fib_stream_checker;

  localparam int W = 4;
  localparam int N = 15;

  logic         Clk = 1'b0;
  logic         Rst_n = 1'b0;
  logic         START = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready, Done, Error;
  logic [7:0]   err_index, term_count;
  logic [W-1:0] err_value;
  logic [1:0]   fsm_state;

  logic         start2 = 1'b0;
  logic [W-1:0] in_data2 = '0;
  logic         in_valid2 = 1'b0;
  logic         in_ready2, done2, error2;
  logic [7:0]   err_index2, term_count2;
  logic [W-1:0] err_value2;
  logic [1:0]   fsm_state2;

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] stim_q[$];
  logic [W-1:0] exp_q[$];

  fib_stream_checker #(.WIDTH(W), .TERMS(N), .SEED_A(1), .SEED_B(1)) u_dut (
    .Clk(Clk), .Rst_n(Rst_n), .START(START), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .Done(Done), .Error(Error),
    .err_index(err_index), .err_value(err_value), .term_count(term_count),
    .fsm_state(fsm_state)
  );

  fib_stream_checker #(.WIDTH(W), .TERMS(2), .SEED_A(3), .SEED_B(5)) u_dut2 (
    .Clk(Clk), .Rst_n(Rst_n), .START(start2), .in_data(in_data2),
    .in_valid(in_valid2), .in_ready(in_ready2), .Done(done2), .Error(error2),
    .err_index(err_index2), .err_value(err_value2), .term_count(term_count2),
    .fsm_state(fsm_state2)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic load_clean();
    int a, b, c;
    stim_q.delete();
    a = 1; b = 1;
    stim_q.push_back(W'(a));
    stim_q.push_back(W'(b));
    for (int i = 2; i < N; i++) begin
      c = (a + b) % 16;
      stim_q.push_back(W'(c));
      a = b; b = c;
    end
  endtask

  // Expected term i: the seeds, then the sum of the two received terms before it.
  task automatic build_expect();
    exp_q.delete();
    for (int i = 0; i < stim_q.size(); i++) begin
      if (i == 0)      exp_q.push_back(W'(1));
      else if (i == 1) exp_q.push_back(W'(1));
      else exp_q.push_back(W'((int'(stim_q[i-1]) + int'(stim_q[i-2])) % 16));
    end
  endtask

  // stall_mode: -1 random 0..3 idle cycles per term, otherwise fixed count.
  task automatic run_stream(input string tag, input int stall_mode);
    int  first_bad;
    int  n_stall;
    build_expect();
    first_bad = -1;
    START = 1'b1;
    @(negedge Clk);
    check({tag, " armed_ready"}, in_ready, 1);
    check({tag, " armed_count"}, term_count, 0);
    check({tag, " armed_error"}, Error, 0);
    for (int i = 0; i < N; i++) begin
      n_stall = (stall_mode < 0) ? $urandom_range(0, 3) : stall_mode;
      if ($urandom_range(0, 1) == 1) START = 1'b0;
      for (int s = 0; s < n_stall; s++) begin
        in_valid = 1'b0;
        in_data  = W'($urandom);
        @(negedge Clk);
        check({tag, " stall_count"}, term_count, i);
      end
      in_valid = 1'b1;
      in_data  = stim_q[i];
      @(negedge Clk);
      if (first_bad < 0 && stim_q[i] != exp_q[i]) first_bad = i;
      check({tag, " count"}, term_count, i + 1);
      check({tag, " done"}, Done, (i == N - 1) ? 1 : 0);
      check({tag, " error"}, Error, (first_bad >= 0) ? 1 : 0);
    end
    in_valid = 1'b0;
    START = 1'b1;
    check({tag, " end_ready"}, in_ready, 0);
    check({tag, " err_index"}, err_index, (first_bad >= 0) ? first_bad : 0);
    check({tag, " err_value"}, err_value, (first_bad >= 0) ? stim_q[first_bad] : 0);
    @(negedge Clk);
    check({tag, " done_hold"}, Done, 1);
    START = 1'b0;
    @(negedge Clk);
    check({tag, " idle_done"}, Done, 0);
    check({tag, " idle_state"}, fsm_state, 0);
    check({tag, " idle_error_kept"}, Error, (first_bad >= 0) ? 1 : 0);
  endtask

  initial begin
    int idx;
    repeat (2) @(negedge Clk);
    check("reset_ready", in_ready, 0);
    check("reset_done", Done, 0);
    check("reset_error", Error, 0);
    check("reset_count", term_count, 0);
    Rst_n = 1'b1;
    @(negedge Clk);

    load_clean();
    run_stream("clean", 0);

    load_clean();
    run_stream("stall3", 3);

    load_clean();
    stim_q[7] = 4'd6;
    run_stream("corrupt7", 0);

    load_clean();
    stim_q[0] = 4'd0;
    run_stream("seed0", 0);

    for (int r = 0; r < 6; r++) begin
      load_clean();
      idx = $urandom_range(0, N - 1);
      stim_q[idx] = stim_q[idx] + W'($urandom_range(1, 15));
      if ($urandom_range(0, 1) == 1) begin
        idx = $urandom_range(0, N - 1);
        stim_q[idx] = W'($urandom);
      end
      run_stream("random", -1);
    end

    load_clean();
    START = 1'b1;
    @(negedge Clk);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = stim_q[i];
      @(negedge Clk);
    end
    check("pre_reset_count", term_count, 5);
    #2;
    Rst_n = 1'b0;
    START = 1'b0;
    in_valid = 1'b0;
    #1;
    check("async_ready", in_ready, 0);
    check("async_count", term_count, 0);
    check("async_done", Done, 0);
    check("async_error", Error, 0);
    check("async_err_index", err_index, 0);
    check("async_err_value", err_value, 0);
    check("async_state", fsm_state, 0);
    @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);
    run_stream("restart", 0);

    start2 = 1'b1;
    @(negedge Clk);
    in_valid2 = 1'b1;
    in_data2  = 4'd3;
    @(negedge Clk);
    check("t2_first_done", done2, 0);
    in_data2  = 4'd4;
    @(negedge Clk);
    in_valid2 = 1'b0;
    check("t2_done", done2, 1);
    check("t2_count", term_count2, 2);
    check("t2_error", error2, 1);
    check("t2_err_index", err_index2, 1);
    check("t2_err_value", err_value2, 4);
    start2 = 1'b0;
    @(negedge Clk);
    check("t2_idle", done2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
